// File: rtl/sram_mem_controller.sv
// ---------------------------------------------------------------------------
// sram_mem_controller
//
// Multi-cycle bridge between the MEM stage and a 16-bit asynchronous SRAM.
// Every 32-bit data access is split into two halfword phases: LOW carries
// bits [15:0] and HIGH carries bits [31:16]. Each phase lasts ACCESS_CYCLES
// clocks. While an access is in flight, ready stays low. The top level uses
// ~ready as the pipeline-wide stall.
//
// Parameters
//   BASE_ADDR      byte address that maps to SRAM halfword 0
//   ACCESS_CYCLES  clocks per halfword phase (must be >= 2)
//
// Ports
//   clk          system clock, rising-edge active
//   rst          synchronous reset, active-low
//   wr_en        store request from MEM, held until ready=1
//   rd_en        load request from MEM, held until ready=1
//   address      word-aligned byte address of the access
//   wdata        store data
//   rdata        load result, complete once the access reaches DONE
//   ready        combinational, 0 stalls the pipeline
//   sram_addr    SRAM halfword address
//   sram_dq_out  data driven onto the SRAM bus
//   sram_dq_in   data read back from the SRAM bus
//   sram_dq_oe   1 when the controller drives the bus
//   sram_we_n    SRAM write enable, active-low
//   sram_oe_n    SRAM output enable, active-low
// ---------------------------------------------------------------------------
module sram_mem_controller #(
  parameter int BASE_ADDR     = 1024,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n,
  output logic        sram_oe_n
);

  // The phase counter only has to reach ACCESS_CYCLES-1.
  localparam int               CNT_W    = $clog2(ACCESS_CYCLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [31:0]      BASE     = 32'(BASE_ADDR);

  typedef enum logic [1:0] {
    IDLE,
    LOW,
    HIGH,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] phase_cnt;
  logic             is_write;
  logic [16:0]      word_idx;
  logic [31:0]      wdata_q;

  logic             request;
  logic [31:0]      req_offset;
  logic             phase_last;
  logic             next_is_last;
  logic             unused_offset_bits;

  assign request    = rd_en | wr_en;
  assign req_offset = address - BASE;

  // The upper offset bits and the byte-lane bits are ignored on purpose.
  // Dropping the upper bits makes out-of-range addresses wrap modulo 512 KB.
  assign unused_offset_bits = &{1'b0, req_offset[31:19], req_offset[1:0]};

  assign phase_last   = (phase_cnt == LAST_CNT);
  assign next_is_last = ((phase_cnt + CNT_W'(1)) == LAST_CNT);

  // An idle controller with a pending request must already stall the
  // pipeline in the request cycle itself.
  assign ready = (state == DONE) | ((state == IDLE) & ~request);

  // All SRAM pins are registered. Each transition loads the values the pins
  // need for the following cycle. In a write phase, we_n drops on phase cycle
  // 0 and rises for the last cycle, so data and address stay stable across
  // the rising edge of we_n.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      phase_cnt   <= '0;
      is_write    <= 1'b0;
      word_idx    <= '0;
      wdata_q     <= '0;
      rdata       <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (request) begin
            // A simultaneous load and store request is treated as a store.
            state       <= LOW;
            phase_cnt   <= '0;
            is_write    <= wr_en;
            word_idx    <= req_offset[18:2];
            wdata_q     <= wdata;
            sram_addr   <= {req_offset[18:2], 1'b0};
            if (wr_en) begin
              sram_dq_out <= wdata[15:0];
              sram_dq_oe  <= 1'b1;
              sram_we_n   <= 1'b0;
              sram_oe_n   <= 1'b1;
            end else begin
              sram_dq_oe  <= 1'b0;
              sram_we_n   <= 1'b1;
              sram_oe_n   <= 1'b0;
            end
          end
        end

        LOW: begin
          if (phase_last) begin
            if (!is_write) begin
              rdata[15:0] <= sram_dq_in;
            end
            state     <= HIGH;
            phase_cnt <= '0;
            sram_addr <= {word_idx, 1'b1};
            if (is_write) begin
              sram_dq_out <= wdata_q[31:16];
              sram_we_n   <= 1'b0;
            end
          end else begin
            phase_cnt <= phase_cnt + CNT_W'(1);
            if (is_write) begin
              sram_we_n <= next_is_last;
            end
          end
        end

        HIGH: begin
          if (phase_last) begin
            if (!is_write) begin
              rdata[31:16] <= sram_dq_in;
            end
            state      <= DONE;
            phase_cnt  <= '0;
            sram_dq_oe <= 1'b0;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
          end else begin
            phase_cnt <= phase_cnt + CNT_W'(1);
            if (is_write) begin
              sram_we_n <= next_is_last;
            end
          end
        end

        // The request is still visible in DONE because it is the one that
        // is completing. DONE therefore always returns to IDLE and never
        // starts a new access.
        DONE: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_mem_controller.sv
// ---------------------------------------------------------------------------
// tb_sram_mem_controller
//
// Bench for sram_mem_controller. It combines a halfword-addressed SRAM model
// with a word-level reference memory. The reference memory is indexed by
// ((address - BASE) >> 2) modulo 2^17. The bench checks reset values, the
// directed store, load, back-to-back, wrap, priority and abort sequences, and
// then a run of random accesses.
// ---------------------------------------------------------------------------
module tb_sram_mem_controller;

  localparam int BASE = 1024;
  localparam int AC   = 2;
  localparam int LAT  = 2 * AC + 1;

  logic        clk     = 1'b0;
  logic        rst     = 1'b0;
  logic        wr_en   = 1'b0;
  logic        rd_en   = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] wdata   = '0;
  logic [31:0] rdata;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;
  logic        sram_oe_n;

  int checks = 0;
  int errors = 0;

  sram_mem_controller #(
    .BASE_ADDR    (BASE),
    .ACCESS_CYCLES(AC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .address    (address),
    .wdata      (wdata),
    .rdata      (rdata),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_in (sram_dq_in),
    .sram_dq_oe (sram_dq_oe),
    .sram_we_n  (sram_we_n),
    .sram_oe_n  (sram_oe_n)
  );

  always #5 clk = ~clk;

  // SRAM model with a combinational read. A write commits on each clock
  // edge where we_n is low. The chip enable is tied to the system reset,
  // so an edge that resets the controller does not write anything.
  logic [15:0] sram [0:262143];
  assign sram_dq_in = sram_oe_n ? 16'h0000 : sram[sram_addr];
  always @(posedge clk) begin
    if (!sram_we_n && sram_dq_oe && rst) sram[sram_addr] <= sram_dq_out;
  end

  // Word-level reference memory.
  logic [31:0] ref_mem [int];
  logic [31:0] exp_rdata;

  // Per-cycle snapshots taken during the most recent access.
  logic [17:0] snap_addr  [0:15];
  logic [15:0] snap_dq    [0:15];
  logic        snap_we    [0:15];
  logic        snap_oen   [0:15];
  logic        snap_ready [0:15];
  int          we_low;

  function automatic int refIndex(input logic [31:0] addr);
    logic [31:0] off;
    off = addr - 32'(BASE);
    return int'((off >> 2) & 32'h1FFFF);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Presents a request and follows it until ready rises. Cycle 0 is the
  // first cycle in which the request is visible in IDLE. When from_done is
  // set, the request is driven during a DONE cycle, and counting starts in
  // the following cycle. The bench changes address and wdata after the
  // request edge to show that the in-flight access ignores them.
  task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] addr,
                               input logic [31:0] wd, input bit from_done,
                               output int lat);
    rd_en   = rd;
    wr_en   = wr;
    address = addr;
    wdata   = wd;
    lat     = -1;
    we_low  = 0;
    if (from_done) @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (k < 16) begin
        snap_addr[k]  = sram_addr;
        snap_dq[k]    = sram_dq_out;
        snap_we[k]    = sram_we_n;
        snap_oen[k]   = sram_oe_n;
        snap_ready[k] = ready;
      end
      if (sram_we_n === 1'b0) we_low++;
      if (k == 1) begin
        address = $urandom;
        wdata   = $urandom;
      end
      if (ready === 1'b1) begin
        lat = k;
        break;
      end
    end
    rd_en = 1'b0;
    wr_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat, lat2;
    logic [31:0] wd, addr;
    int op, w, up;

    // Preload words 0..15 with random data. Word 1 holds the directed load
    // pattern.
    for (int i = 0; i < 16; i++) begin
      wd = $urandom;
      if (i == 1) wd = 32'hFFFF_F9F6;
      sram[2*i]     = wd[15:0];
      sram[2*i + 1] = wd[31:16];
      ref_mem[i]    = wd;
    end
    exp_rdata = 32'h0;

    // Reset held for two edges with a pending store request.
    rst = 1'b0; wr_en = 1'b1; address = 32'd1024; wdata = 32'h1111_2222;
    @(negedge clk); #1;
    checkOutput("reset_we_n_first", 32'(sram_we_n), 32'd1);
    @(negedge clk); #1;
    checkOutput("reset_rdata", rdata, 32'h0);
    checkOutput("reset_sram_addr", 32'(sram_addr), 32'h0);
    checkOutput("reset_dq_out", 32'(sram_dq_out), 32'h0);
    checkOutput("reset_dq_oe", 32'(sram_dq_oe), 32'd0);
    checkOutput("reset_we_n", 32'(sram_we_n), 32'd1);
    checkOutput("reset_oe_n", 32'(sram_oe_n), 32'd1);
    checkOutput("reset_ready_pending", 32'(ready), 32'd0);
    rst = 1'b1; wr_en = 1'b0;
    @(negedge clk);

    // Store to 1024.
    applyStimulus(1'b0, 1'b1, 32'd1024, 32'h0000_060A, 1'b0, lat);
    ref_mem[0] = 32'h0000_060A;
    checkOutput("store_latency", 32'(lat), 32'(LAT));
    checkOutput("store_ready_c0", 32'(snap_ready[0]), 32'd0);
    checkOutput("store_addr_c1", 32'(snap_addr[1]), 32'h0);
    checkOutput("store_dq_c1", 32'(snap_dq[1]), 32'h060A);
    checkOutput("store_we_c1", 32'(snap_we[1]), 32'd0);
    checkOutput("store_we_c2", 32'(snap_we[2]), 32'd1);
    checkOutput("store_addr_c3", 32'(snap_addr[3]), 32'h1);
    checkOutput("store_dq_c3", 32'(snap_dq[3]), 32'h0000);
    checkOutput("store_we_low_cycles", 32'(we_low), 32'(2 * (AC - 1)));
    checkOutput("store_sram_lo", 32'(sram[0]), 32'h060A);
    checkOutput("store_sram_hi", 32'(sram[1]), 32'h0000);
    @(negedge clk);

    // Load from 1028.
    applyStimulus(1'b1, 1'b0, 32'd1028, 32'h0, 1'b0, lat);
    exp_rdata = ref_mem[refIndex(32'd1028)];
    checkOutput("load_latency", 32'(lat), 32'(LAT));
    checkOutput("load_oe_n_c1", 32'(snap_oen[1]), 32'd0);
    checkOutput("load_rdata", rdata, 32'hFFFF_F9F6);
    @(negedge clk);

    // A following store leaves rdata unchanged.
    wd = $urandom;
    applyStimulus(1'b0, 1'b1, 32'd1032, wd, 1'b0, lat);
    ref_mem[refIndex(32'd1032)] = wd;
    checkOutput("store_keeps_rdata", rdata, exp_rdata);
    @(negedge clk);

    // Back-to-back store and load, with the load presented during DONE.
    applyStimulus(1'b0, 1'b1, 32'd1024, 32'h0000_060A, 1'b0, lat);
    ref_mem[0] = 32'h0000_060A;
    applyStimulus(1'b1, 1'b0, 32'd1024, 32'h0, 1'b1, lat2);
    exp_rdata = ref_mem[0];
    checkOutput("b2b_second_ready", 32'(lat + 1 + lat2), 32'(2 * LAT + 1));
    checkOutput("b2b_rdata", rdata, 32'h0000_060A);
    @(negedge clk);

    // Wrap plus priority: both enables set at 1024+0x80000 is a store to word 0.
    wd = $urandom;
    applyStimulus(1'b1, 1'b1, 32'd1024 + 32'h80000, wd, 1'b0, lat);
    ref_mem[0] = wd;
    checkOutput("wrap_addr_lo", 32'(snap_addr[1]), 32'h0);
    checkOutput("wrap_addr_hi", 32'(snap_addr[3]), 32'h1);
    checkOutput("prio_we_c1", 32'(snap_we[1]), 32'd0);
    checkOutput("prio_keeps_rdata", rdata, exp_rdata);
    checkOutput("prio_sram_lo", 32'(sram[0]), 32'(wd[15:0]));
    @(negedge clk);

    // Byte offset 0x410 maps to halfwords 0x208 and 0x209.
    wd = $urandom;
    applyStimulus(1'b0, 1'b1, 32'd1024 + 32'h410, wd, 1'b0, lat);
    ref_mem[refIndex(32'd1024 + 32'h410)] = wd;
    checkOutput("map_addr_lo", 32'(snap_addr[1]), 32'h208);
    checkOutput("map_addr_hi", 32'(snap_addr[3]), 32'h209);
    @(negedge clk);

    // Abort: reset during the HIGH phase of a store to word 5.
    applyStimulus(1'b0, 1'b1, 32'd1044, 32'hAAAA_5555, 1'b0, lat);
    @(negedge clk);
    wr_en = 1'b1; address = 32'd1044; wdata = 32'h1234_BEEF;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("abort_in_high_addr", 32'(sram_addr), 32'd11);
    checkOutput("abort_in_high_we", 32'(sram_we_n), 32'd0);
    rst = 1'b0; wr_en = 1'b0;
    @(negedge clk); #1;
    checkOutput("abort_we_n", 32'(sram_we_n), 32'd1);
    checkOutput("abort_dq_oe", 32'(sram_dq_oe), 32'd0);
    checkOutput("abort_idle_ready", 32'(ready), 32'd1);
    checkOutput("abort_rdata", rdata, 32'h0);
    exp_rdata = 32'h0;
    ref_mem[5] = {16'hAAAA, 16'hBEEF};
    rst = 1'b1;
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 32'd1044, 32'h0, 1'b0, lat);
    exp_rdata = ref_mem[5];
    checkOutput("abort_reload", rdata, 32'hAAAA_BEEF);
    @(negedge clk);

    // Random accesses over words 0..15 with random wrap bits.
    for (int n = 0; n < 24; n++) begin
      op   = int'($urandom_range(0, 2));
      w    = int'($urandom_range(0, 15));
      up   = int'($urandom_range(0, 3));
      addr = 32'(BASE) + 32'(w * 4) + 32'(up) * 32'h80000;
      wd   = $urandom;
      applyStimulus(op != 1, op != 0, addr, wd, 1'b0, lat);
      checkOutput("rand_latency", 32'(lat), 32'(LAT));
      if (op == 0) begin
        exp_rdata = ref_mem[refIndex(addr)];
        checkOutput("rand_load", rdata, exp_rdata);
      end else begin
        ref_mem[refIndex(addr)] = wd;
        checkOutput("rand_store_rdata", rdata, exp_rdata);
      end
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
